// File: rtl/i2c_pkg.sv
// Command encoding and state set shared by the transaction
// sequencer and its byte buffer.
package i2c_pkg;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b01;
    localparam logic [1:0] RW_READ  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        W_DEV,
        W_ADDR,
        W_DATA,
        R_DEV,
        R_DATA,
        FIN
    } seq_state_e;

    // Engine command implied by a sequencer state.
    function automatic logic [1:0] rw_of(seq_state_e s);
        case (s)
            W_DEV, W_ADDR, W_DATA: rw_of = RW_WRITE;
            R_DEV, R_DATA:         rw_of = RW_READ;
            default:               rw_of = RW_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/i2c_seq_buf.sv
// Payload/result byte store: one write port, two async read ports.
// Out-of-range writes are dropped and out-of-range reads return zero.
module i2c_seq_buf #(
    parameter int NB = 56,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [7:0]    rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [7:0]    rdata_b
);

    localparam logic [AW-1:0] LIMIT = AW'(NB);

    logic [7:0] mem [NB];

    always_ff @(posedge clk) begin
        if (we && (waddr < LIMIT)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a < LIMIT) ? mem[raddr_a] : 8'h00;
    assign rdata_b = (raddr_b < LIMIT) ? mem[raddr_b] : 8'h00;

endmodule

// File: rtl/i2c_xfer_seq.sv
// Turns one host command into a register write or a pointer write
// plus repeated-start read on the i2c byte engine.
module i2c_xfer_seq
    import i2c_pkg::*;
#(
    parameter int NB      = 56,
    parameter int AW      = 6,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          wr_nrd,
    input  logic [7:0]    dev_addr,
    input  logic [7:0]    addr,
    input  logic [AW-1:0] len,
    input  logic          buf_we,
    input  logic [AW-1:0] buf_waddr,
    input  logic [7:0]    buf_wdata,
    input  logic [AW-1:0] buf_raddr,
    output logic [7:0]    buf_rdata,
    output logic [1:0]    rw,
    output logic [7:0]    wr_data,
    input  logic          wr_ready,
    input  logic [7:0]    rd_data,
    input  logic          rd_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] NB_L   = AW'(NB);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    seq_state_e    state, state_n;
    logic [7:0]    wr_data_n;
    logic [AW-1:0] idx, idx_n, idx_inc;
    logic [CW-1:0] cnt, cnt_n;
    logic          err_n;
    logic          take;
    logic          hs;
    logic          last;
    logic          wr_nrd_q;
    logic [6:0]    dev_q;
    logic [7:0]    addr_q;
    logic [AW-1:0] len_q;
    logic          seq_we;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [AW-1:0] fetch_addr;
    logic [7:0]    fetch_data;
    logic          unused_dev0;

    assign unused_dev0 = dev_addr[0];
    assign idx_inc     = idx + 1'b1;
    assign last        = (idx_inc == len_q);
    assign hs          = (state == R_DATA) ? rd_ready : wr_ready;
    assign fetch_addr  = (state == W_DATA) ? idx_inc : '0;

    // Received bytes own the write port while busy; host writes only when idle.
    assign mem_we    = seq_we | (buf_we & ~busy);
    assign mem_waddr = seq_we ? idx : buf_waddr;
    assign mem_wdata = seq_we ? rd_data : buf_wdata;

    i2c_seq_buf #(
        .NB(NB),
        .AW(AW)
    ) u_buf (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (buf_raddr),
        .rdata_a (buf_rdata),
        .raddr_b (fetch_addr),
        .rdata_b (fetch_data)
    );

    always_comb begin
        state_n   = state;
        wr_data_n = wr_data;
        idx_n     = idx;
        err_n     = err;
        take      = 1'b0;
        seq_we    = 1'b0;
        cnt_n     = (busy && !hs) ? cnt + 1'b1 : '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len > NB_L) begin
                        state_n = FIN;
                        err_n   = 1'b1;
                    end else begin
                        take      = 1'b1;
                        err_n     = 1'b0;
                        state_n   = W_DEV;
                        wr_data_n = {dev_addr[7:1], 1'b0};
                    end
                end
            end
            W_DEV: begin
                if (wr_ready) begin
                    state_n   = W_ADDR;
                    wr_data_n = addr_q;
                end
            end
            W_ADDR: begin
                if (wr_ready) begin
                    if (len_q == '0) begin
                        state_n = FIN;
                    end else if (wr_nrd_q) begin
                        state_n   = W_DATA;
                        idx_n     = '0;
                        wr_data_n = fetch_data;
                    end else begin
                        state_n   = R_DEV;
                        wr_data_n = {dev_q, 1'b1};
                    end
                end
            end
            W_DATA: begin
                if (wr_ready) begin
                    if (last) begin
                        state_n = FIN;
                    end else begin
                        idx_n     = idx_inc;
                        wr_data_n = fetch_data;
                    end
                end
            end
            R_DEV: begin
                if (wr_ready) begin
                    state_n = R_DATA;
                    idx_n   = '0;
                end
            end
            R_DATA: begin
                if (rd_ready) begin
                    seq_we = 1'b1;
                    if (last) state_n = FIN;
                    else      idx_n   = idx_inc;
                end
            end
            default: state_n = IDLE;
        endcase
        // A stalled engine aborts the transfer; bytes already read stay put.
        if (busy && !hs && (cnt == T_LAST)) begin
            state_n = FIN;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rw       <= RW_IDLE;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            wr_nrd_q <= 1'b0;
            dev_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
        end else begin
            state   <= state_n;
            rw      <= rw_of(state_n);
            busy    <= (rw_of(state_n) != RW_IDLE);
            done    <= (state_n == FIN);
            wr_data <= wr_data_n;
            err     <= err_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            if (take) begin
                wr_nrd_q <= wr_nrd;
                dev_q    <= dev_addr[7:1];
                addr_q   <= addr;
                len_q    <= len;
            end
        end
    end

endmodule
